// File: rtl/reg_file.sv
// reg_file: 32 x DATA_W MIPS register file, two async reads, one sync write.
// $0 reads zero. Optional write-to-read bypass under `REGFILE_BYPASS_EN.
// Ports: clk, rst (sync, active-high); ra1/ra2 -> rd1/rd2 read ports;
//        we/wa/wd write port (wa from destination-select mux).
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic              wr_en;

  assign wr_en = we && !rst && (wa != '0);

  always_comb begin
    regs_d = regs_q;
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_d[i] = '0;
      end
    end else if (wr_en) begin
      regs_d[wa] = wd;
    end
    // $0 is never stored, whatever happens above
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    regs_q <= regs_d;
  end

  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] ra
  );
    logic [DATA_W-1:0] val;
    val = regs_q[ra];
`ifdef REGFILE_BYPASS_EN
    // forward writeback data to decode in the same cycle
    if (wr_en && (ra == wa)) begin
      val = wd;
    end
`endif
    if (ra == '0) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rd1 = rd_port(ra1);
    rd2 = rd_port(ra2);
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: directed self-checking bench for reg_file.
// Build with or without +define+REGFILE_BYPASS_EN.
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;

  int checks;
  int failures;

  reg_file #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ra1(ra1),
    .ra2(ra2),
    .rd1(rd1),
    .rd2(rd2),
    .we (we),
    .wa (wa),
    .wd (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(
    input string       tag,
    input logic [4:0]  a1,
    input logic [31:0] e1,
    input logic [4:0]  a2,
    input logic [31:0] e2
  );
    ra1 = a1;
    ra2 = a2;
    #1;
    chk({tag, "_rd1"}, rd1, e1);
    chk({tag, "_rd2"}, rd2, e2);
  endtask

  logic [31:0] byp_exp;

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    we  = 1'b0;
    wa  = '0;
    wd  = '0;
    ra1 = '0;
    ra2 = '0;
    tick();
    rst = 1'b0;

    for (int i = 0; i < 32; i++) begin
      rd_chk("post_rst", 5'(i), 32'h0, 5'(31 - i), 32'h0);
    end

    we = 1'b1;
    for (int i = 1; i < 32; i++) begin
      wa = 5'(i);
      wd = 32'hC000_0000 | 32'(i);
      tick();
    end
    we = 1'b0;
    rd_chk("fill_a", 5'd1, 32'hC000_0001, 5'd31, 32'hC000_001F);
    rd_chk("fill_b", 5'd16, 32'hC000_0010, 5'd0, 32'h0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rd_chk("mid_rst", 5'(i), 32'h0, 5'(i), 32'h0);
    end

    we = 1'b1;
    wa = 5'd5;
    wd = 32'hDEADBEEF;
    tick();
    we = 1'b0;
    rd_chk("basic", 5'd5, 32'hDEADBEEF, 5'd6, 32'h0);
    rd_chk("same_addr", 5'd5, 32'hDEADBEEF, 5'd5, 32'hDEADBEEF);

    we = 1'b1;
    wa = 5'd0;
    wd = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      rd_chk("zero_guard", 5'd0, 32'h0, 5'd0, 32'h0);
    end
    we = 1'b0;
    tick();
    rd_chk("zero_after", 5'd0, 32'h0, 5'd5, 32'hDEADBEEF);

    we = 1'b0;
    wa = 5'd7;
    wd = 32'h12345678;
    tick();
    tick();
    rd_chk("we_low", 5'd7, 32'h0, 5'd5, 32'hDEADBEEF);

    rst = 1'b1;
    we  = 1'b1;
    wa  = 5'd9;
    wd  = 32'hA5A5A5A5;
    tick();
    rst = 1'b0;
    we  = 1'b0;
    rd_chk("rst_vs_wr", 5'd9, 32'h0, 5'd5, 32'h0);

    we = 1'b1;
    wa = 5'd3;
    wd = 32'h1;
    tick();
    we = 1'b0;
    rd_chk("byp_pre", 5'd3, 32'h1, 5'd4, 32'h0);

`ifdef REGFILE_BYPASS_EN
    byp_exp = 32'h2;
`else
    byp_exp = 32'h1;
`endif
    we = 1'b1;
    wa = 5'd3;
    wd = 32'h2;
    rd_chk("byp_same", 5'd3, byp_exp, 5'd3, byp_exp);
    rd_chk("byp_other", 5'd3, byp_exp, 5'd4, 32'h0);
    tick();
    we = 1'b0;
    rd_chk("byp_next", 5'd3, 32'h2, 5'd3, 32'h2);

    we = 1'b1;
    wa = 5'd0;
    wd = 32'h5555AAAA;
    rd_chk("byp_zero", 5'd0, 32'h0, 5'd3, 32'h2);
    tick();
    we = 1'b0;

    rst = 1'b1;
    we  = 1'b1;
    wa  = 5'd3;
    wd  = 32'h77;
    rd_chk("byp_rst", 5'd3, 32'h2, 5'd0, 32'h0);
    tick();
    rst = 1'b0;
    we  = 1'b0;
    rd_chk("final", 5'd3, 32'h0, 5'd31, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
